// File: rtl/instr_fetch_unit_if.sv
// Instruction bus between the fetch unit (master/producer) and the control unit (slave).
interface instr_fetch_unit_if;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;

  modport master (output instruction, output instr_valid, input instr_ready);
  modport slave  (input instruction, input instr_valid, output instr_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Program memory and sequencer; issues datapath words over a valid/ready bus.
// Define INSTR_FETCH_LOOP_EN to enable the single-level counted hardware loop.
module instr_fetch_unit #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DEPTH      = 64,  // must equal 2**ADDR_WIDTH
  parameter logic [3:0]  OP_HALT    = 4'hF,
  parameter logic [3:0]  OP_JUMP    = 4'hE,
  parameter logic [3:0]  OP_LOOP    = 4'hD
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_en,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [15:0]           load_data,
  input  logic                  start,
  instr_fetch_unit_if.master    ibus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [1:0]  state;
  logic [15:0] mem [DEPTH];
  logic [15:0] word;
  logic [3:0]  opcode;
  logic [15:0] instr_q;
  logic        valid_q;
  logic        can_load;

`ifdef INSTR_FETCH_LOOP_EN
  logic       loop_active;
  logic [3:0] loop_cnt;
  logic [3:0] loop_n;
`endif

  always_comb begin
    word     = mem[pc];
    opcode   = word[15:12];
    can_load = load_en && ((state == S_IDLE) || (state == S_HALTED));
    busy     = (state == S_FETCH) || (state == S_ISSUE);
    done     = (state == S_HALTED);
    ibus.instruction = instr_q;
    ibus.instr_valid = valid_q;
`ifdef INSTR_FETCH_LOOP_EN
    loop_n   = word[11:8];
`endif
  end

  // Memory has no reset: program contents survive reset_n.
  always_ff @(posedge clock) begin
    if (can_load) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
`ifdef INSTR_FETCH_LOOP_EN
      loop_active <= 1'b0;
      loop_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HALTED: begin
          // A load in the same cycle wins over start.
          if (start && !load_en) begin
            pc    <= '0;
            state <= S_FETCH;
`ifdef INSTR_FETCH_LOOP_EN
            loop_active <= 1'b0;
            loop_cnt    <= '0;
`endif
          end
        end

        S_FETCH: begin
          if (opcode == OP_HALT) begin
            state <= S_HALTED;
          end else if (opcode == OP_JUMP) begin
            pc <= word[ADDR_WIDTH-1:0];
`ifdef INSTR_FETCH_LOOP_EN
          end else if (opcode == OP_LOOP) begin
            if (!loop_active) begin
              if (loop_n == 4'd0) begin
                pc <= pc + PC_ONE;
              end else begin
                loop_active <= 1'b1;
                loop_cnt    <= loop_n - 4'd1;
                pc          <= word[ADDR_WIDTH-1:0];
              end
            end else if (loop_cnt == 4'd0) begin
              loop_active <= 1'b0;
              pc          <= pc + PC_ONE;
            end else begin
              loop_cnt <= loop_cnt - 4'd1;
              pc       <= word[ADDR_WIDTH-1:0];
            end
`endif
          end else begin
            instr_q <= word;
            valid_q <= 1'b1;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (ibus.instr_ready) begin
            valid_q <= 1'b0;
            pc      <= pc + PC_ONE;
            state   <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
